// File: rtl/max7219_checker_pkg.sv
// Shared constants, register layout and address helpers for the MAX7219 chain checker.
package max7219_checker_pkg;

  localparam logic [3:0] AddrNoop        = 4'h0;
  localparam logic [3:0] AddrDigit0      = 4'h1;
  localparam logic [3:0] AddrDigit7      = 4'h8;
  localparam logic [3:0] AddrDecodeMode  = 4'h9;
  localparam logic [3:0] AddrIntensity   = 4'hA;
  localparam logic [3:0] AddrScanLimit   = 4'hB;
  localparam logic [3:0] AddrShutdown    = 4'hC;
  localparam logic [3:0] AddrIllegalD    = 4'hD;
  localparam logic [3:0] AddrIllegalE    = 4'hE;
  localparam logic [3:0] AddrDisplayTest = 4'hF;

  localparam int unsigned WordBits    = 16;
  localparam int unsigned BitCntWidth = 8;
  localparam logic [BitCntWidth-1:0] BitCntMax = 8'hFF;

  typedef struct packed {
    logic [7:0][7:0] digit;
    logic [7:0]      decode_mode;
    logic [7:0]      intensity;
    logic [7:0]      scan_limit;
    logic [7:0]      shutdown;
    logic [7:0]      display_test;
  } dev_regs_t;

  function automatic logic addr_is_illegal(input logic [3:0] addr);
    return (addr == AddrIllegalD) || (addr == AddrIllegalE);
  endfunction

  function automatic logic addr_is_writable(input logic [3:0] addr);
    return (addr != AddrNoop) && !addr_is_illegal(addr);
  endfunction

endpackage

// File: rtl/max7219_reg_file.sv
// Register set of one emulated MAX7219: one write port, one combinational read port.
module max7219_reg_file
  import max7219_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output dev_regs_t  o_regs
);

  dev_regs_t r_regs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (i_wr_en) begin
      case (i_wr_addr)
        AddrDecodeMode:  r_regs.decode_mode  <= i_wr_data;
        AddrIntensity:   r_regs.intensity    <= i_wr_data;
        AddrScanLimit:   r_regs.scan_limit   <= i_wr_data;
        AddrShutdown:    r_regs.shutdown     <= i_wr_data;
        AddrDisplayTest: r_regs.display_test <= i_wr_data;
        default: begin
          // Digit addresses 1..8 map to digit 0..7; address 8 wraps 0-1 to 7 in three bits.
          if (i_wr_addr >= AddrDigit0 && i_wr_addr <= AddrDigit7) begin
            r_regs.digit[i_wr_addr[2:0] - 3'd1] <= i_wr_data;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_rd_data = 8'h00;
    case (i_rd_addr)
      AddrDecodeMode:  o_rd_data = r_regs.decode_mode;
      AddrIntensity:   o_rd_data = r_regs.intensity;
      AddrScanLimit:   o_rd_data = r_regs.scan_limit;
      AddrShutdown:    o_rd_data = r_regs.shutdown;
      AddrDisplayTest: o_rd_data = r_regs.display_test;
      default: begin
        if (i_rd_addr >= AddrDigit0 && i_rd_addr <= AddrDigit7) begin
          o_rd_data = r_regs.digit[i_rd_addr[2:0] - 3'd1];
        end
      end
    endcase
  end

  assign o_regs = r_regs;

endmodule

// File: rtl/max7219_chain_checker.sv
// Behavioural checker emulating a daisy chain of MAX7219 devices on a serial SCLK/DIN/LOAD bus.
module max7219_chain_checker
  import max7219_checker_pkg::*;
#(
  parameter int unsigned G_NB_MATRIX = 4,
  parameter bit          G_LOAD_EDGE = 1'b1,
  parameter int unsigned G_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_max7219_clk,
  input  logic                   i_max7219_din,
  input  logic                   i_max7219_load,
  output logic                   o_max7219_dout,
  input  logic                   i_rd_en,
  input  logic [2:0]             i_rd_dev,
  input  logic [3:0]             i_rd_addr,
  output logic [7:0]             o_rd_data,
  output logic                   o_rd_valid,
  input  logic                   i_display_reg,
  output logic                   o_frame_received,
  output logic                   o_frame_error,
  output logic [G_CNT_WIDTH-1:0] o_frame_cnt
);

  localparam int unsigned FrameBits = WordBits * G_NB_MATRIX;

  logic                   r_sclk;
  logic                   r_load;
  logic                   r_disp;
  logic [FrameBits-1:0]   r_shift;
  logic [BitCntWidth-1:0] r_bit_cnt;
  logic                   r_dout;
  logic                   r_frame_received;
  logic                   r_frame_error;
  logic [G_CNT_WIDTH-1:0] r_frame_cnt;
  logic [7:0]             r_rd_data;
  logic                   r_rd_valid;

  logic                   w_sclk_rise;
  logic                   w_load_edge;
  logic                   w_cnt_ok;
  logic                   w_commit;
  logic [G_NB_MATRIX-1:0] w_illegal;
  logic [G_NB_MATRIX-1:0] w_wr_en;
  logic [7:0]             w_dev_rd_data [G_NB_MATRIX];
  dev_regs_t              w_regs [G_NB_MATRIX];
  logic [7:0]             w_rd_sel;

  // Edges compare the live input with its registered copy, so they are seen in the same cycle.
  assign w_sclk_rise = i_max7219_clk & ~r_sclk;
  assign w_load_edge = G_LOAD_EDGE ? (i_max7219_load & ~r_load) : (~i_max7219_load & r_load);
  assign w_cnt_ok    = (r_bit_cnt == BitCntWidth'(FrameBits));
  assign w_commit    = w_load_edge & w_cnt_ok;

  for (genvar k = 0; k < G_NB_MATRIX; k++) begin : g_dev
    logic [3:0] w_addr;
    logic [7:0] w_data;

    // Decode reads the pre-shift contents even when an SCLK edge lands on the LOAD edge.
    assign w_addr       = r_shift[WordBits*k+8 +: 4];
    assign w_data       = r_shift[WordBits*k +: 8];
    assign w_illegal[k] = addr_is_illegal(w_addr);
    assign w_wr_en[k]   = w_commit & addr_is_writable(w_addr);

    max7219_reg_file u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en[k]),
      .i_wr_addr (w_addr),
      .i_wr_data (w_data),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (w_dev_rd_data[k]),
      .o_regs    (w_regs[k])
    );
  end

  always_comb begin
    w_rd_sel = 8'h00;
    for (int k = 0; k < G_NB_MATRIX; k++) begin
      if (i_rd_dev == 3'(k)) begin
        w_rd_sel = w_dev_rd_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk           <= 1'b0;
      r_load           <= 1'b0;
      r_disp           <= 1'b0;
      r_shift          <= '0;
      r_bit_cnt        <= '0;
      r_dout           <= 1'b0;
      r_frame_received <= 1'b0;
      r_frame_error    <= 1'b0;
      r_frame_cnt      <= '0;
      r_rd_data        <= 8'h00;
      r_rd_valid       <= 1'b0;
    end else begin
      r_sclk <= i_max7219_clk;
      r_load <= i_max7219_load;
      r_disp <= i_display_reg;

      if (w_sclk_rise) begin
        r_shift <= {r_shift[FrameBits-2:0], i_max7219_din};
      end

      if (w_load_edge) begin
        r_bit_cnt <= w_sclk_rise ? BitCntWidth'(1) : '0;
      end else if (w_sclk_rise && r_bit_cnt != BitCntMax) begin
        r_bit_cnt <= r_bit_cnt + BitCntWidth'(1);
      end

      r_dout           <= r_shift[FrameBits-1];
      r_frame_received <= w_commit;
      r_frame_error    <= w_load_edge & (~w_cnt_ok | (|w_illegal));

      if (w_commit && r_frame_cnt != '1) begin
        r_frame_cnt <= r_frame_cnt + G_CNT_WIDTH'(1);
      end

      r_rd_valid <= i_rd_en;
      r_rd_data  <= i_rd_en ? w_rd_sel : 8'h00;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && i_display_reg && !r_disp) begin
      for (int k = 0; k < G_NB_MATRIX; k++) begin
        $display("max7219 dev %0d: digit7..0=%h decode=%h intensity=%h scan=%h shutdown=%h test=%h",
                 k, w_regs[k].digit, w_regs[k].decode_mode, w_regs[k].intensity,
                 w_regs[k].scan_limit, w_regs[k].shutdown, w_regs[k].display_test);
      end
    end
  end
`endif

  assign o_max7219_dout   = r_dout;
  assign o_frame_received = r_frame_received;
  assign o_frame_error    = r_frame_error;
  assign o_frame_cnt      = r_frame_cnt;
  assign o_rd_data        = r_rd_data;
  assign o_rd_valid       = r_rd_valid;

endmodule

// File: tb/tb_max7219_chain_checker.sv
// Directed bench for max7219_chain_checker with four chained devices.
module tb_max7219_chain_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_max7219_clk = 1'b0;
  logic        i_max7219_din = 1'b0;
  logic        i_max7219_load = 1'b0;
  logic        o_max7219_dout;
  logic        i_rd_en = 1'b0;
  logic [2:0]  i_rd_dev = 3'd0;
  logic [3:0]  i_rd_addr = 4'd0;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        i_display_reg = 1'b0;
  logic        o_frame_received;
  logic        o_frame_error;
  logic [15:0] o_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_total = 0;
  int err_total = 0;

  max7219_chain_checker #(
    .G_NB_MATRIX (4),
    .G_LOAD_EDGE (1'b1),
    .G_CNT_WIDTH (16)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_max7219_clk    (i_max7219_clk),
    .i_max7219_din    (i_max7219_din),
    .i_max7219_load   (i_max7219_load),
    .o_max7219_dout   (o_max7219_dout),
    .i_rd_en          (i_rd_en),
    .i_rd_dev         (i_rd_dev),
    .i_rd_addr        (i_rd_addr),
    .o_rd_data        (o_rd_data),
    .o_rd_valid       (o_rd_valid),
    .i_display_reg    (i_display_reg),
    .o_frame_received (o_frame_received),
    .o_frame_error    (o_frame_error),
    .o_frame_cnt      (o_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame_received === 1'b1) rx_total++;
    if (o_frame_error === 1'b1) err_total++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    i_max7219_din = b;
    i_max7219_clk = 1'b1;
    repeat (2) @(negedge clk);
    i_max7219_clk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    i_max7219_load = 1'b1;
    repeat (2) @(negedge clk);
    i_max7219_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_max7219_clk = 1'b0;
    i_max7219_load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_reg(input logic [2:0] dev, input logic [3:0] addr,
                          output logic [7:0] data, output logic vld, output logic vld_next);
    @(negedge clk);
    i_rd_en = 1'b1;
    i_rd_dev = dev;
    i_rd_addr = addr;
    @(negedge clk);
    i_rd_en = 1'b0;
    data = o_rd_data;
    vld = o_rd_valid;
    @(negedge clk);
    vld_next = o_rd_valid;
  endtask

  initial begin
    logic [7:0]  rd;
    logic        v;
    logic        vn;
    int          rx0;
    int          err0;
    logic [63:0] pat;
    logic [63:0] got;

    // Reset state
    do_reset();
    check("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    check("rst_dout", 64'(o_max7219_dout), 64'd0);
    check("rst_rx", 64'(o_frame_received), 64'd0);
    check("rst_err", 64'(o_frame_error), 64'd0);
    check("rst_rd_valid", 64'(o_rd_valid), 64'd0);
    check("rst_rd_data", 64'(o_rd_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic configuration frame: first word shifted lands in dev3
    rx0 = rx_total; err0 = err_total;
    send_word(16'h0A05); send_word(16'h0B07); send_word(16'h0C01); send_word(16'h0F00);
    pulse_load();
    check("f1_rx_pulses", 64'(rx_total - rx0), 64'd1);
    check("f1_err_pulses", 64'(err_total - err0), 64'd0);
    check("f1_frame_cnt", 64'(o_frame_cnt), 64'd1);
    read_reg(3'd3, 4'hA, rd, v, vn);
    check("f1_dev3_intensity", 64'(rd), 64'h05);
    check("f1_rd_valid", 64'(v), 64'd1);
    check("f1_rd_valid_drop", 64'(vn), 64'd0);
    read_reg(3'd2, 4'hB, rd, v, vn);
    check("f1_dev2_scan", 64'(rd), 64'h07);
    read_reg(3'd1, 4'hC, rd, v, vn);
    check("f1_dev1_shutdown", 64'(rd), 64'h01);
    read_reg(3'd0, 4'hF, rd, v, vn);
    check("f1_dev0_test", 64'(rd), 64'h00);
    read_reg(3'd3, 4'hB, rd, v, vn);
    check("f1_dev3_scan_untouched", 64'(rd), 64'h00);

    // Short frame: 63 bits
    rx0 = rx_total; err0 = err_total;
    send_word(16'h0A7F); send_word(16'h0A7F); send_word(16'h0A7F);
    for (int i = 15; i >= 1; i--) send_bit(1'b1);
    pulse_load();
    check("short_err_pulses", 64'(err_total - err0), 64'd1);
    check("short_rx_pulses", 64'(rx_total - rx0), 64'd0);
    check("short_frame_cnt", 64'(o_frame_cnt), 64'd1);
    read_reg(3'd3, 4'hA, rd, v, vn);
    check("short_dev3_intensity", 64'(rd), 64'h05);

    // Partially illegal frame: dev1 uses address 0xD
    rx0 = rx_total; err0 = err_total;
    send_word(16'h0155); send_word(16'h0155); send_word(16'h0D12); send_word(16'h0155);
    pulse_load();
    check("ill_err_pulses", 64'(err_total - err0), 64'd1);
    check("ill_rx_pulses", 64'(rx_total - rx0), 64'd1);
    check("ill_frame_cnt", 64'(o_frame_cnt), 64'd2);
    read_reg(3'd0, 4'h1, rd, v, vn);
    check("ill_dev0_digit0", 64'(rd), 64'h55);
    read_reg(3'd1, 4'h1, rd, v, vn);
    check("ill_dev1_digit0", 64'(rd), 64'h00);
    read_reg(3'd2, 4'h1, rd, v, vn);
    check("ill_dev2_digit0", 64'(rd), 64'h55);
    read_reg(3'd3, 4'h1, rd, v, vn);
    check("ill_dev3_digit0", 64'(rd), 64'h55);

    // Out-of-range device and illegal address reads
    read_reg(3'd5, 4'h1, rd, v, vn);
    check("oor_dev_data", 64'(rd), 64'h00);
    check("oor_dev_valid", 64'(v), 64'd1);
    check("oor_dev_valid_drop", 64'(vn), 64'd0);
    read_reg(3'd0, 4'hD, rd, v, vn);
    check("addr_d_data", 64'(rd), 64'h00);

    // DOUT: bit k (1-based) reappears after SCLK edge k+63
    pat = 64'hF0E1_D2C3_B4A5_9687;
    got = '0;
    for (int k = 1; k <= 128; k++) begin
      send_bit(k <= 64 ? pat[64-k] : 1'(k));
      @(negedge clk);
      if (k >= 64 && k <= 127) got = {got[62:0], o_max7219_dout};
    end
    check("dout_delay_64", got, pat);

    // Reset mid-frame, then a lone LOAD, then a full frame
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    do_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_frame_cnt", 64'(o_frame_cnt), 64'd0);
    rx0 = rx_total; err0 = err_total;
    pulse_load();
    check("rst2_empty_load_err", 64'(err_total - err0), 64'd1);
    check("rst2_empty_load_rx", 64'(rx_total - rx0), 64'd0);
    send_word(16'h0933); send_word(16'h0844); send_word(16'h0A0F); send_word(16'h0F01);
    pulse_load();
    check("rst2_frame_cnt_after", 64'(o_frame_cnt), 64'd1);
    read_reg(3'd3, 4'h9, rd, v, vn);
    check("rst2_dev3_decode", 64'(rd), 64'h33);
    read_reg(3'd2, 4'h8, rd, v, vn);
    check("rst2_dev2_digit7", 64'(rd), 64'h44);
    read_reg(3'd1, 4'hA, rd, v, vn);
    check("rst2_dev1_intensity", 64'(rd), 64'h0F);
    read_reg(3'd0, 4'hF, rd, v, vn);
    check("rst2_dev0_test", 64'(rd), 64'h01);
    read_reg(3'd3, 4'h1, rd, v, vn);
    check("rst2_dev3_digit0_cleared", 64'(rd), 64'h00);
    read_reg(3'd3, 4'hA, rd, v, vn);
    check("rst2_dev3_intensity_cleared", 64'(rd), 64'h00);

    @(negedge clk);
    i_display_reg = 1'b1;
    repeat (2) @(negedge clk);
    i_display_reg = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
